gray_lbp_host: RTL and testbench

//  Host-side responder for the LBP engine's memory interfaces. It holds the 128x128 grayscale

---
 rtl/gray_lbp_host.sv | 171 +++++++++++++++++
 tb/tb_gray_lbp_host.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_lbp_host.sv
// Host-side responder for the LBP engine: loads and serves the grayscale image
// (1-cycle read latency), collects LBP results, flags border writes, and offers readback.
module gray_lbp_host #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int IMG_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              done,
  output logic [ADDR_W:0]   lbp_count,
  output logic              border_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SERVE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic                gray_ready_q, gray_ready_d;
  logic [DATA_W-1:0]   gray_data_q, gray_data_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     lbp_count_q, lbp_count_d;
  logic                border_err_q, border_err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [DATA_W-1:0]   gray_mem [DEPTH];
  logic [DATA_W-1:0]   lbp_mem  [DEPTH];

  logic                gray_we;
  logic                lbp_we;
  logic [DATA_W-1:0]   gray_rd_word;
  logic [DATA_W-1:0]   lbp_rd_word;
  logic [ADDR_W-1:0]   lbp_row;
  logic [ADDR_W-1:0]   lbp_col;
  logic                lbp_on_border;

  assign gray_we = (state_q == ST_LOAD)  && load_valid;
  assign lbp_we  = (state_q == ST_SERVE) && lbp_valid;

  assign gray_rd_word = gray_mem[gray_addr];
  assign lbp_rd_word  = lbp_mem[rd_addr];

  // Row/column split of the result address; border = outermost ring of the image.
  assign lbp_row = lbp_addr / IMG_W_A;
  assign lbp_col = lbp_addr % IMG_W_A;
  assign lbp_on_border = (lbp_row == '0) || (lbp_row == IMG_LAST) ||
                         (lbp_col == '0) || (lbp_col == IMG_LAST);

  // Memories are deliberately left out of reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && gray_we) begin
      gray_mem[ld_cnt_q] <= load_data;
    end
    if (!reset && lbp_we) begin
      lbp_mem[lbp_addr] <= lbp_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    gray_ready_d = gray_ready_q;
    gray_data_d  = gray_data_q;
    done_d       = done_q;
    lbp_count_d  = lbp_count_q;
    border_err_d = border_err_q;
    rd_data_d    = lbp_rd_word;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          // The final beat fills the last word; results of the previous run are dropped here.
          if (ld_cnt_q == '1) begin
            state_d      = ST_SERVE;
            gray_ready_d = 1'b1;
            lbp_count_d  = '0;
            border_err_d = 1'b0;
          end
        end
      end
      ST_SERVE: begin
        if (gray_req) begin
          gray_data_d = gray_rd_word;
        end
        if (lbp_valid) begin
          if (lbp_count_q != CNT_MAX) begin
            lbp_count_d = lbp_count_q + 1'b1;
          end
          if (lbp_on_border) begin
            border_err_d = 1'b1;
          end
        end
        if (finish) begin
          state_d      = ST_DONE;
          gray_ready_d = 1'b0;
          done_d       = 1'b1;
        end
      end
      ST_DONE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
          done_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ld_cnt_q     <= '0;
      gray_ready_q <= 1'b0;
      gray_data_q  <= '0;
      done_q       <= 1'b0;
      lbp_count_q  <= '0;
      border_err_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      gray_ready_q <= gray_ready_d;
      gray_data_q  <= gray_data_d;
      done_q       <= done_d;
      lbp_count_q  <= lbp_count_d;
      border_err_q <= border_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign gray_ready = gray_ready_q;
  assign gray_data  = gray_data_q;
  assign done       = done_q;
  assign lbp_count  = lbp_count_q;
  assign border_err = border_err_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_gray_lbp_host.sv
// Directed bench for gray_lbp_host: image loads, reads, result writes, border flag, run control.
module tb_gray_lbp_host;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, load_valid;
  logic [DW-1:0] load_data;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          done;
  logic [AW:0]   lbp_count;
  logic          border_err;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int checks   = 0;
  int failures = 0;

  gray_lbp_host #(.ADDR_W(AW), .DATA_W(DW), .IMG_W(128)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .done(done), .lbp_count(lbp_count), .border_err(border_err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic [AW-1:0] gaddr;
    logic          wv;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic          chk_rd;
    logic [DW-1:0] exp_gd;
    logic [AW:0]   exp_cnt;
    logic          exp_berr;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    load_start = 0; load_valid = 0; load_data = '0;
    gray_req = 0; gray_addr = '0;
    lbp_valid = 0; lbp_addr = '0; lbp_data = '0;
    finish = 0;
  endtask

  // Full image load; inv selects ~addr data, gap inserts an idle beat before each valid beat.
  task automatic full_load(input bit inv, input bit gap, input logic [AW:0] pre_cnt,
                           input logic pre_berr);
    logic [AW-1:0] a;
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      if (gap) begin
        load_valid = 0; tick();
      end
      if (i == DEPTH - 1) begin
        chk("ready_before_last_beat", {31'd0, gray_ready}, 32'd0);
        chk("count_kept_in_load", {17'd0, lbp_count}, {17'd0, pre_cnt});
        chk("berr_kept_in_load", {31'd0, border_err}, {31'd0, pre_berr});
        chk("done_low_in_load", {31'd0, done}, 32'd0);
      end
      load_valid = 1;
      load_data  = inv ? ~a[7:0] : a[7:0];
      tick();
    end
    load_valid = 0;
    chk("ready_after_last_beat", {31'd0, gray_ready}, 32'd1);
    chk("count_clear_on_serve", {17'd0, lbp_count}, 32'd0);
    chk("berr_clear_on_serve", {31'd0, border_err}, 32'd0);
  endtask

  initial begin
    // {req, gaddr, wv, waddr, wdata, raddr, chk_rd, exp_gd, exp_cnt, exp_berr, exp_rd}
    tbl[0] = '{1'b1, 14'h0105, 1'b1, 14'd129,   8'hA5, 14'd129,   1'b0, 8'h05, 15'd1, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 14'h0000, 1'b1, 14'd254,   8'h22, 14'd129,   1'b1, 8'h05, 15'd2, 1'b0, 8'hA5};
    tbl[2] = '{1'b1, 14'h3FFF, 1'b1, 14'd16254, 8'h33, 14'd254,   1'b1, 8'hFF, 15'd3, 1'b0, 8'h22};
    tbl[3] = '{1'b1, 14'h2A80, 1'b0, 14'd0,     8'h00, 14'd16254, 1'b1, 8'h80, 15'd3, 1'b0, 8'h33};
    tbl[4] = '{1'b0, 14'h0000, 1'b1, 14'd129,   8'h5A, 14'd129,   1'b1, 8'h80, 15'd4, 1'b0, 8'hA5};
    tbl[5] = '{1'b0, 14'h0000, 1'b0, 14'd0,     8'h00, 14'd129,   1'b1, 8'h80, 15'd4, 1'b0, 8'h5A};
    tbl[6] = '{1'b1, 14'h0007, 1'b1, 14'd130,   8'h77, 14'd254,   1'b1, 8'h07, 15'd5, 1'b0, 8'h22};

    idle_inputs();
    rd_addr = '0;
    reset = 1;
    repeat (3) tick();
    reset = 0;
    chk("rst_gray_ready", {31'd0, gray_ready}, 32'd0);
    chk("rst_gray_data", {24'd0, gray_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_lbp_count", {17'd0, lbp_count}, 32'd0);
    chk("rst_border_err", {31'd0, border_err}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);

    finish = 1; tick(); finish = 0;
    chk("finish_ignored_idle", {31'd0, done}, 32'd0);

    // Reset in the middle of a load, then stray beats before the next load_start.
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 500; i++) begin
      load_valid = 1; load_data = 8'hEE; tick();
    end
    reset = 1; tick(); reset = 0; load_valid = 0;
    chk("midload_reset_ready", {31'd0, gray_ready}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      load_valid = 1; load_data = 8'hEE; tick();
    end
    load_valid = 0;
    chk("stray_beats_ready", {31'd0, gray_ready}, 32'd0);

    full_load(1'b0, 1'b0, 15'd0, 1'b0);

    gray_req = 1; gray_addr = 14'h0105; tick();
    chk("read_0105", {24'd0, gray_data}, 32'h05);
    for (int i = 10; i <= 12; i++) begin
      gray_addr = AW'(i); tick();
      chk("b2b_read", {24'd0, gray_data}, i);
    end
    gray_req = 0; tick();
    chk("read_hold", {24'd0, gray_data}, 32'd12);

    for (int i = 0; i < 7; i++) begin
      gray_req = tbl[i].req; gray_addr = tbl[i].gaddr;
      lbp_valid = tbl[i].wv; lbp_addr = tbl[i].waddr; lbp_data = tbl[i].wdata;
      rd_addr = tbl[i].raddr;
      tick();
      chk($sformatf("tbl%0d_gray_data", i), {24'd0, gray_data}, {24'd0, tbl[i].exp_gd});
      chk($sformatf("tbl%0d_count", i), {17'd0, lbp_count}, {17'd0, tbl[i].exp_cnt});
      chk($sformatf("tbl%0d_berr", i), {31'd0, border_err}, {31'd0, tbl[i].exp_berr});
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd_data", i), {24'd0, rd_data}, {24'd0, tbl[i].exp_rd});
    end
    idle_inputs();

    load_start = 1; lbp_valid = 1; lbp_addr = 14'd400; lbp_data = 8'h44; tick();
    idle_inputs();
    chk("load_start_ignored_serve", {31'd0, gray_ready}, 32'd1);
    chk("serve_write_count", {17'd0, lbp_count}, 32'd6);

    // finish with a simultaneous read and write: both complete.
    finish = 1; gray_req = 1; gray_addr = 14'h0042;
    lbp_valid = 1; lbp_addr = 14'd300; lbp_data = 8'h99; tick();
    idle_inputs();
    chk("finish_done", {31'd0, done}, 32'd1);
    chk("finish_ready_low", {31'd0, gray_ready}, 32'd0);
    chk("finish_read_done", {24'd0, gray_data}, 32'h42);
    chk("finish_write_count", {17'd0, lbp_count}, 32'd7);
    lbp_valid = 1; lbp_addr = 14'd301; gray_req = 1; gray_addr = 14'h0011; rd_addr = 14'd300;
    tick();
    idle_inputs();
    chk("write_ignored_done", {17'd0, lbp_count}, 32'd7);
    chk("read_ignored_done", {24'd0, gray_data}, 32'h42);
    chk("readback_300", {24'd0, rd_data}, 32'h99);

    full_load(1'b1, 1'b1, 15'd7, 1'b0);
    gray_req = 1; gray_addr = 14'h0105; tick(); gray_req = 0;
    chk("read_inv_0105", {24'd0, gray_data}, 32'hFA);

    lbp_valid = 1; lbp_addr = 14'd129; lbp_data = 8'hA5; tick();
    chk("w129_count", {17'd0, lbp_count}, 32'd1);
    chk("w129_no_border", {31'd0, border_err}, 32'd0);
    lbp_addr = 14'd0; lbp_data = 8'h11; tick();
    chk("w0_count", {17'd0, lbp_count}, 32'd2);
    chk("w0_border", {31'd0, border_err}, 32'd1);
    finish = 1; lbp_addr = 14'd130; lbp_data = 8'hC3; tick();
    idle_inputs();
    chk("fin_w130_count", {17'd0, lbp_count}, 32'd3);
    chk("fin_w130_done", {31'd0, done}, 32'd1);
    chk("border_sticky_done", {31'd0, border_err}, 32'd1);
    rd_addr = 14'd130; tick();
    chk("readback_130", {24'd0, rd_data}, 32'hC3);
    rd_addr = 14'd0; tick();
    chk("readback_0", {24'd0, rd_data}, 32'h11);

    full_load(1'b0, 1'b0, 15'd3, 1'b1);
    finish = 1; tick(); finish = 0;
    chk("empty_run_done", {31'd0, done}, 32'd1);
    chk("empty_run_count", {17'd0, lbp_count}, 32'd0);
    chk("empty_run_berr", {31'd0, border_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
